// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions: instruction-cache frame layout, address split and fill FSM states.
package CPU_TYPES;

  localparam int ITAG_W = 26;
  localparam int IIDX_W = 4;
  localparam int IBYT_W = 2;

  typedef struct packed {
    logic [ITAG_W-1:0] tag;
    logic [IIDX_W-1:0] idx;
    logic [IBYT_W-1:0] bytoff;
  } icachef_t;

  typedef struct packed {
    logic              valid;
    logic [ITAG_W-1:0] tag;
    logic [31:0]       data;
  } icache_frame;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } icache_state_t;

  function automatic icachef_t word_align(input logic [31:0] a);
    return icachef_t'({a[31:IBYT_W], {IBYT_W{1'b0}}});
  endfunction

endpackage

// File: rtl/icache.sv
// Direct-mapped 16-frame instruction cache; 0-cycle hit, single-word blocking fill from memory.
// Optional hit/miss counters when ICACHE_STATS_EN is defined.
module icache
  import CPU_TYPES::*;
(
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  input  logic        flush,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
`ifdef ICACHE_STATS_EN
  input  logic [31:0] iload,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`else
  input  logic [31:0] iload
`endif
);

  localparam int NFRAMES = 1 << IIDX_W;

  icache_state_t     state_q, state_d;
  icachef_t          miss_addr_q, miss_addr_d;
  logic              kill_q, kill_d;
  logic [NFRAMES-1:0] valid_q, valid_d;
  logic [ITAG_W-1:0] tag_q [NFRAMES];
  logic [31:0]       data_q [NFRAMES];

  icachef_t lookup;
  logic     tag_match;
  logic     miss_go;
  logic     fill_done;
  logic     fill_we;

  assign lookup    = icachef_t'(imemaddr);
  assign tag_match = valid_q[lookup.idx] && (tag_q[lookup.idx] == lookup.tag);

  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    kill_d      = kill_q;
    valid_d     = valid_q;
    miss_go     = 1'b0;
    fill_done   = 1'b0;
    fill_we     = 1'b0;

    ihit     = imemREN && tag_match && (state_q == IDLE) && !flush;
    imemload = ihit ? data_q[lookup.idx] : 32'h0;

    case (state_q)
      IDLE: begin
        if (imemREN && !tag_match && !flush) begin
          miss_go     = 1'b1;
          state_d     = FETCH;
          miss_addr_d = word_align(imemaddr);
          kill_d      = 1'b0;
        end
      end
      FETCH: begin
        // A flush during the fill poisons it; the handshake still runs to completion.
        kill_d = kill_q | flush;
        if (!iwait) begin
          fill_done = 1'b1;
          fill_we   = !kill_q && !flush;
          state_d   = IDLE;
          kill_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (fill_we) valid_d[miss_addr_q.idx] = 1'b1;
    if (flush) valid_d = '0;

    iREN  = (state_q == FETCH);
    iaddr = (state_q == FETCH) ? 32'(miss_addr_q) : 32'h0;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      miss_addr_q <= '0;
      kill_q      <= 1'b0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      kill_q      <= kill_d;
      valid_q     <= valid_d;
    end
  end

  // Tag/data storage is qualified by valid, so it carries no reset.
  always_ff @(posedge CLK) begin
    if (fill_we) begin
      tag_q[miss_addr_q.idx]  <= miss_addr_q.tag;
      data_q[miss_addr_q.idx] <= iload;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  always_comb begin
    hit_count_d  = hit_count_q + 32'(ihit);
    miss_count_d = miss_count_q + 32'(miss_go);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

  logic unused_ok;
  assign unused_ok = fill_done;

endmodule

// File: tb/tb_icache.sv
// Scoreboarded bench for icache: a bench-side memory model supplies fills and expected words.
module tb_icache;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        flush;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q [$];

  icache dut (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .flush(flush), .iREN(iREN),
    .iaddr(iaddr), .iwait(iwait),
`ifdef ICACHE_STATS_EN
    .iload(iload), .hit_count(hit_count), .miss_count(miss_count)
`else
    .iload(iload)
`endif
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[15:0], ~a[15:0]} ^ 32'h00A5_5A00;
    if (a == 32'h40) w = 32'h0000_0013;
    return w;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One fetch from request to hit, with the bench acting as memory.
  task automatic fetch(input logic [31:0] a, input int wt, input bit exp_miss, input string nm);
    int fc;
    bit done;
    bit hit_due;
    bit was_miss;
    logic [31:0] exp;
    fc = 0; done = 0; hit_due = 0;
    imemREN = 1'b1; imemaddr = a; iwait = 1'b1;
    exp_q.push_back(mem_word({a[31:2], 2'b00}));
    #1;
    for (int c = 0; c < 64 && !done; c++) begin
      if (ihit) begin
        exp = exp_q.pop_front();
        total++;
        if (imemload !== exp) begin
          bad++; $display("FAIL %s data: got %h want %h", nm, imemload, exp);
        end
        was_miss = (fc != 0);
        total++;
        if (was_miss !== exp_miss) begin
          bad++; $display("FAIL %s miss: got %0d want %0d", nm, was_miss, exp_miss);
        end
        if (was_miss) begin
          total++;
          if (fc !== wt + 1) begin
            bad++; $display("FAIL %s fetch_cycles: got %0d want %0d", nm, fc, wt + 1);
          end
        end
        done = 1;
      end else if (hit_due) begin
        total++; bad++;
        $display("FAIL %s fill_to_hit: ihit got 0 want 1", nm);
        void'(exp_q.pop_front());
        done = 1;
      end else if (iREN) begin
        total++;
        if (iaddr !== {a[31:2], 2'b00}) begin
          bad++; $display("FAIL %s iaddr: got %h want %h", nm, iaddr, {a[31:2], 2'b00});
        end
        iwait = (fc < wt);
        iload = (fc < wt) ? 32'hDEAD_BEEF : mem_word(iaddr);
        hit_due = !iwait;
        fc++;
        tick();
        iwait = 1'b1;
      end else begin
        tick();
      end
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL %s timeout: got no hit want hit", nm);
      void'(exp_q.pop_front());
    end
    tick();
    imemREN = 1'b0;
  endtask

  task automatic do_reset();
    nRST = 1'b0; imemREN = 1'b0; imemaddr = '0; flush = 1'b0; iwait = 1'b1; iload = '0;
    tick(); tick();
    nRST = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    nRST = 1'b0; imemREN = 1'b1; imemaddr = 32'h40; flush = 1'b0; iwait = 1'b1; iload = '0;
    tick();
    total++; if (ihit !== 1'b0) begin bad++; $display("FAIL reset_ihit: got %b want 0", ihit); end
    total++; if (imemload !== 32'h0) begin bad++; $display("FAIL reset_imemload: got %h want 0", imemload); end
    total++; if (iREN !== 1'b0) begin bad++; $display("FAIL reset_iREN: got %b want 0", iREN); end
    total++; if (iaddr !== 32'h0) begin bad++; $display("FAIL reset_iaddr: got %h want 0", iaddr); end
    imemREN = 1'b0;
    nRST = 1'b1;
    tick();
  endtask

  task automatic test_cold_miss();
    fetch(32'h40, 3, 1'b1, "cold_miss");
    fetch(32'h40, 0, 1'b0, "warm_hit");
    fetch(32'h43, 0, 1'b0, "byte_offset_hit");
  endtask

  task automatic test_idle();
    imemREN = 1'b0; imemaddr = 32'h3F0;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if (iREN !== 1'b0 || ihit !== 1'b0) begin
        bad++; $display("FAIL idle_quiet: got iREN=%b ihit=%b want 0 0", iREN, ihit);
      end
    end
  endtask

  task automatic test_conflict();
    fetch(32'h80, 1, 1'b1, "conflict_miss");
    fetch(32'h80, 0, 1'b0, "conflict_hit");
    fetch(32'h40, 2, 1'b1, "conflict_evicted");
  endtask

  task automatic test_redirect();
    logic [31:0] exp;
    imemREN = 1'b1; imemaddr = 32'h100; iwait = 1'b1;
    #1;
    tick();
    imemaddr = 32'h200;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (iaddr !== 32'h100 || iREN !== 1'b1) begin
        bad++; $display("FAIL redirect_iaddr: got %h/%b want 00000100/1", iaddr, iREN);
      end
      iwait = (k < 2);
      iload = (k < 2) ? 32'hDEAD_BEEF : mem_word(32'h100);
      tick();
    end
    iwait = 1'b1;
    imemaddr = 32'h100;
    exp_q.push_back(mem_word(32'h100));
    #1;
    exp = exp_q.pop_front();
    total++;
    if (ihit !== 1'b1 || imemload !== exp) begin
      bad++; $display("FAIL redirect_fill: got ihit=%b %h want 1 %h", ihit, imemload, exp);
    end
    imemaddr = 32'h200;
    #1;
    total++;
    if (ihit !== 1'b0) begin bad++; $display("FAIL redirect_new_miss: got ihit=%b want 0", ihit); end
    fetch(32'h200, 1, 1'b1, "redirect_refetch");
  endtask

  task automatic test_flush_fetch();
    imemREN = 1'b1; imemaddr = 32'h44; iwait = 1'b1;
    #1;
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    total++;
    if (iREN !== 1'b1 || iaddr !== 32'h44) begin
      bad++; $display("FAIL flush_handshake: got %b/%h want 1/00000044", iREN, iaddr);
    end
    iwait = 1'b0; iload = mem_word(32'h44);
    tick();
    iwait = 1'b1;
    total++;
    if (ihit !== 1'b0 || iREN !== 1'b0) begin
      bad++; $display("FAIL flush_killed_fill: got ihit=%b iREN=%b want 0 0", ihit, iREN);
    end
    imemREN = 1'b0;
    tick();
    fetch(32'h44, 0, 1'b1, "flush_refetch");

    imemREN = 1'b1; imemaddr = 32'h48; iwait = 1'b1;
    #1;
    tick();
    iwait = 1'b0; iload = mem_word(32'h48); flush = 1'b1;
    tick();
    flush = 1'b0; iwait = 1'b1;
    #1;
    total++;
    if (ihit !== 1'b0) begin bad++; $display("FAIL flush_same_edge: got ihit=%b want 0", ihit); end
    imemREN = 1'b0;
    tick();
    fetch(32'h48, 1, 1'b1, "flush_same_edge_refetch");
  endtask

  task automatic test_warm_fill();
    for (int i = 0; i < 16; i++) fetch(32'(i * 4), 0, 1'b1, "warm_fill");
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    logic [31:0] exp;
    imemREN = 1'b1;
    for (int i = 0; i < 16; i++) begin
      a = 32'((i * 7 % 16) * 4);
      imemaddr = a;
      exp_q.push_back(mem_word(a));
      #1;
      exp = exp_q.pop_front();
      total++;
      if (ihit !== 1'b1 || imemload !== exp) begin
        bad++; $display("FAIL back_to_back %h: got ihit=%b %h want 1 %h", a, ihit, imemload, exp);
      end
      tick();
    end
    imemREN = 1'b0;
  endtask

  task automatic test_flush_all();
    imemREN = 1'b1; imemaddr = 32'h8; flush = 1'b1;
    #1;
    total++;
    if (ihit !== 1'b0 || imemload !== 32'h0) begin
      bad++; $display("FAIL flush_masks_hit: got ihit=%b %h want 0 0", ihit, imemload);
    end
    tick();
    flush = 1'b0; imemREN = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) fetch(32'(i * 4), 0, 1'b1, "post_flush_miss");
  endtask

  task automatic test_reset_mid_fetch();
    imemREN = 1'b1; imemaddr = 32'h3C0; iwait = 1'b1;
    #1;
    tick();
    total++;
    if (iREN !== 1'b1) begin bad++; $display("FAIL pre_reset_fetch: got iREN=%b want 1", iREN); end
    nRST = 1'b0;
    #1;
    total++;
    if (iREN !== 1'b0 || iaddr !== 32'h0 || ihit !== 1'b0 || imemload !== 32'h0) begin
      bad++; $display("FAIL async_reset_outputs: got %b %h %b %h want all 0", iREN, iaddr, ihit, imemload);
    end
`ifdef ICACHE_STATS_EN
    total++;
    if (hit_count !== 32'h0 || miss_count !== 32'h0) begin
      bad++; $display("FAIL async_reset_counts: got %0d %0d want 0 0", hit_count, miss_count);
    end
`endif
    imemREN = 1'b0;
    tick();
    nRST = 1'b1;
    tick();
    fetch(32'h0, 0, 1'b1, "after_reset_cold");
  endtask

`ifdef ICACHE_STATS_EN
  task automatic test_stats();
    do_reset();
    fetch(32'h40, 1, 1'b1, "stats_miss");
    for (int k = 0; k < 5; k++) fetch(32'h40, 0, 1'b0, "stats_hit");
    total++;
    if (miss_count !== 32'd1 || hit_count !== 32'd6) begin
      bad++; $display("FAIL stats_counts: got miss=%0d hit=%0d want 1 6", miss_count, hit_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_cold_miss();
    test_idle();
    test_conflict();
    test_redirect();
    test_flush_fetch();
    test_warm_fill();
    test_back_to_back();
    test_flush_all();
`ifdef ICACHE_STATS_EN
    test_stats();
`endif
    test_reset_mid_fetch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
